// File: rtl/efpga_cfg_pkg.sv
// Shared types and constants for the eFPGA configuration controller.
// Optional feature macro: EFPGA_CFG_CRC_EN (adds the CHK state and the CRC-32 trailer check).
package efpga_cfg_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SYNC_W  = 8;
  localparam int unsigned CHAIN_W = 4;
  localparam int unsigned HCNT_W  = 16;

  // Header field positions within a 32-bit stream word
  localparam int unsigned HDR_SYNC_MSB  = 31;
  localparam int unsigned HDR_SYNC_LSB  = 24;
  localparam int unsigned HDR_CHAIN_MSB = 19;
  localparam int unsigned HDR_CHAIN_LSB = 16;
  localparam int unsigned HDR_CNT_MSB   = 15;
  localparam int unsigned HDR_CNT_LSB   = 0;

  localparam logic [SYNC_W-1:0]  SYNC      = 8'hA5;
  localparam logic [CHAIN_W-1:0] CHAIN_END = 4'hF;

  // Reflected CRC-32 parameters
  localparam logic [WORD_W-1:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [WORD_W-1:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] CRC_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
`ifdef EFPGA_CFG_CRC_EN
    ,
    ST_CHK  = 3'd5
`endif
  } cfg_state_e;

endpackage

// File: rtl/efpga_crc32_step.sv
// One full 32-bit word of reflected CRC-32 update per cycle, bits consumed LSB-first.
module efpga_crc32_step
  import efpga_cfg_pkg::*;
(
  input  logic [WORD_W-1:0] crc_in,
  input  logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] crc_c
);

  logic [WORD_W-1:0] acc;

  // Unrolled bit-serial shift register: fold the word in, then 32 conditional polynomial XORs
  always_comb begin
    acc = crc_in ^ data;
    for (int i = 0; i < 32; i++) begin
      if (acc[0]) acc = (acc >> 1) ^ CRC_POLY;
      else        acc = acc >> 1;
    end
    crc_c = acc;
  end

endmodule

// File: rtl/efpga_cfg_ctrl.sv
// eFPGA configuration controller: parses framed config stream, drives one-hot chain shifts.
// Optional feature macro: EFPGA_CFG_CRC_EN (per-frame CRC-32 trailer checked in CHK state).
module efpga_cfg_ctrl
  import efpga_cfg_pkg::*;
#(
  parameter int unsigned NCHAIN = 9,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] prog_i,
  output logic [NCHAIN-1:0] prog_shft,
  input  logic              data_en_i,
  output logic              data_en,
  output logic              fabric_en,
  output logic              cfg_busy,
  output logic              cfg_err
);

  cfg_state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [WORD_W-1:0]  prog_i_d;
  logic [NCHAIN-1:0]  prog_shft_d;
  logic               cfg_ready_d, fabric_en_d, cfg_busy_d, cfg_err_d;

  logic               accept_c;
  logic [SYNC_W-1:0]  hdr_sync_c;
  logic [CHAIN_W-1:0] hdr_chain_c;
  logic [HCNT_W-1:0]  hdr_cnt_c;
  logic               hdr_end_c, hdr_bad_c, last_word_c;

`ifdef EFPGA_CFG_CRC_EN
  logic [WORD_W-1:0]  crc_q, crc_d, crc_step_c;
  logic               crc_match_c;

  efpga_crc32_step u_crc (
    .crc_in (crc_q),
    .data   (cfg_data),
    .crc_c  (crc_step_c)
  );

  assign crc_match_c = ((crc_q ^ CRC_XOROUT) == cfg_data);
`endif

  assign accept_c    = cfg_valid & cfg_ready;
  assign hdr_sync_c  = cfg_data[HDR_SYNC_MSB:HDR_SYNC_LSB];
  assign hdr_chain_c = cfg_data[HDR_CHAIN_MSB:HDR_CHAIN_LSB];
  assign hdr_cnt_c   = cfg_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_end_c   = (hdr_sync_c == SYNC) && (hdr_chain_c == CHAIN_END);
  assign hdr_bad_c   = (hdr_sync_c != SYNC) || (32'(hdr_chain_c) >= NCHAIN) ||
                       (hdr_cnt_c == HCNT_W'(0));
  assign last_word_c = (cnt_q == CNT_W'(1));

  // Fabric data enable is a pure gate of the user request by the configured flag
  assign data_en = data_en_i & fabric_en;

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (accept_c) begin
          if (hdr_end_c)      state_d = ST_DONE;
          else if (hdr_bad_c) state_d = ST_ERR;
          else                state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept_c && last_word_c) begin
`ifdef EFPGA_CFG_CRC_EN
          state_d = ST_CHK;
`else
          state_d = ST_HDR;
`endif
        end
      end
`ifdef EFPGA_CFG_CRC_EN
      ST_CHK: begin
        if (accept_c) state_d = crc_match_c ? ST_HDR : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    prog_i_d    = prog_i;
    prog_shft_d = '0;
    cnt_d       = cnt_q;
    chain_d     = chain_q;
    fabric_en_d = fabric_en;
    cfg_busy_d  = cfg_busy;
    cfg_err_d   = cfg_err;
    cfg_ready_d = (state_d == ST_HDR) || (state_d == ST_LOAD);
`ifdef EFPGA_CFG_CRC_EN
    crc_d       = crc_q;
    cfg_ready_d = cfg_ready_d || (state_d == ST_CHK);
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          cfg_busy_d  = 1'b1;
          cfg_err_d   = 1'b0;
          fabric_en_d = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          if (hdr_end_c) begin
            fabric_en_d = 1'b1;
            cfg_busy_d  = 1'b0;
          end else if (hdr_bad_c) begin
            cfg_err_d   = 1'b1;
            cfg_busy_d  = 1'b0;
            fabric_en_d = 1'b0;
          end else begin
            chain_d = hdr_chain_c;
            cnt_d   = CNT_W'(hdr_cnt_c);
`ifdef EFPGA_CFG_CRC_EN
            crc_d   = CRC_INIT;
`endif
          end
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          prog_i_d    = cfg_data;
          prog_shft_d = NCHAIN'(1) << chain_q;
          cnt_d       = cnt_q - CNT_W'(1);
`ifdef EFPGA_CFG_CRC_EN
          crc_d       = crc_step_c;
`endif
        end
      end
`ifdef EFPGA_CFG_CRC_EN
      ST_CHK: begin
        if (accept_c && !crc_match_c) begin
          cfg_err_d   = 1'b1;
          cfg_busy_d  = 1'b0;
          fabric_en_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      prog_i    <= '0;
      prog_shft <= '0;
      cfg_ready <= 1'b0;
      fabric_en <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_err   <= 1'b0;
      cnt_q     <= '0;
      chain_q   <= '0;
`ifdef EFPGA_CFG_CRC_EN
      crc_q     <= CRC_INIT;
`endif
    end else begin
      prog_i    <= prog_i_d;
      prog_shft <= prog_shft_d;
      cfg_ready <= cfg_ready_d;
      fabric_en <= fabric_en_d;
      cfg_busy  <= cfg_busy_d;
      cfg_err   <= cfg_err_d;
      cnt_q     <= cnt_d;
      chain_q   <= chain_d;
`ifdef EFPGA_CFG_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_efpga_cfg_ctrl.sv
// Directed self-checking bench for efpga_cfg_ctrl (default build; CRC scenario when EFPGA_CFG_CRC_EN).
`timescale 1ns/1ps
module tb_efpga_cfg_ctrl;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_data = 32'h0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] prog_i;
  logic [8:0]  prog_shft;
  logic        data_en_i = 1'b0;
  logic        data_en;
  logic        fabric_en;
  logic        cfg_busy;
  logic        cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tb_crc = 32'hFFFF_FFFF;

  efpga_cfg_ctrl #(.NCHAIN(9), .CNT_W(16)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .prog_i    (prog_i),
    .prog_shft (prog_shft),
    .data_en_i (data_en_i),
    .data_en   (data_en),
    .fabric_en (fabric_en),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference reflected CRC-32 word update, bit-serial
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 32; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    cfg_valid = v;
    cfg_data  = d;
  endtask

  task automatic header(input logic [31:0] d);
    drive(1'b1, d);
    tb_crc = 32'hFFFF_FFFF;
  endtask

  task automatic payload(input logic [31:0] d);
    drive(1'b1, d);
    tb_crc = crc_upd(tb_crc, d);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends the frame trailer when the CRC option is built in
  task automatic end_frame();
`ifdef EFPGA_CFG_CRC_EN
    drive(1'b1, tb_crc ^ 32'hFFFF_FFFF);
    step();
    drive(1'b0, 32'h0);
`endif
  endtask

  task automatic test_reset();
    data_en_i = 1'b1;
    #2 res = 1'b1;
    #1;
    n_checks++;
    if ({prog_i, prog_shft, cfg_ready, fabric_en, data_en, cfg_busy, cfg_err} !== 46'h0) begin
      n_fail++;
      $display("FAIL reset_async: prog_i=%h shft=%h rdy=%b fab=%b den=%b busy=%b err=%b expected all 0",
               prog_i, prog_shft, cfg_ready, fabric_en, data_en, cfg_busy, cfg_err);
    end
    step();
    res = 1'b0;
    drive(1'b1, 32'hA501_0001);
    step();
    step();
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en, prog_shft} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_wait_start: rdy/busy/err/fab=%b%b%b%b shft=%h expected 0000/000",
               cfg_ready, cfg_busy, cfg_err, fabric_en, prog_shft);
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic test_basic_frame();
    logic [31:0] w [3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    pulse_start();
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== 4'b1100) begin
      n_fail++;
      $display("FAIL basic_start: rdy/busy/err/fab=%b%b%b%b expected 1100", cfg_ready, cfg_busy, cfg_err, fabric_en);
    end
    header(32'hA501_0003);
    step();
    n_checks++;
    if (prog_shft !== 9'h000 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hdr: shft=%h rdy=%b expected 000/1", prog_shft, cfg_ready);
    end
    for (int i = 0; i < 3; i++) begin
      payload(w[i]);
      step();
      n_checks++;
      if (prog_shft !== 9'h002 || prog_i !== w[i]) begin
        n_fail++;
        $display("FAIL basic_word%0d: shft=%h prog_i=%h expected 002/%h", i, prog_shft, prog_i, w[i]);
      end
    end
    end_frame();
    header(32'hA50F_0000);
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en, data_en} !== 5'b00011 || prog_shft !== 9'h0 ||
        prog_i !== 32'h33) begin
      n_fail++;
      $display("FAIL basic_done: rdy/busy/err/fab/den=%b%b%b%b%b shft=%h prog_i=%h expected 00011/000/00000033",
               cfg_ready, cfg_busy, cfg_err, fabric_en, data_en, prog_shft, prog_i);
    end
    drive(1'b1, 32'hA501_0001);
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== 4'b0001 || prog_shft !== 9'h0) begin
      n_fail++;
      $display("FAIL done_ignore: rdy/busy/err/fab=%b%b%b%b shft=%h expected 0001/000",
               cfg_ready, cfg_busy, cfg_err, fabric_en, prog_shft);
    end
  endtask

  task automatic test_bad_header();
    logic [31:0] bad [4];
    bad[0] = 32'h5A01_0001; bad[1] = 32'hA509_0001; bad[2] = 32'hA501_0000; bad[3] = 32'h5A0F_0000;
    for (int i = 0; i < 4; i++) begin
      pulse_start();
      n_checks++;
      if ({cfg_ready, cfg_busy, cfg_err, fabric_en, data_en} !== 5'b11000) begin
        n_fail++;
        $display("FAIL bad%0d_start: rdy/busy/err/fab/den=%b%b%b%b%b expected 11000",
                 i, cfg_ready, cfg_busy, cfg_err, fabric_en, data_en);
      end
      header(bad[i]);
      step();
      drive(1'b1, 32'h1122_3344);
      n_checks++;
      if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== 4'b0010 || prog_shft !== 9'h0) begin
        n_fail++;
        $display("FAIL bad%0d_hdr: rdy/busy/err/fab=%b%b%b%b shft=%h expected 0010/000",
                 i, cfg_ready, cfg_busy, cfg_err, fabric_en, prog_shft);
      end
      step();
      drive(1'b0, 32'h0);
      n_checks++;
      if (prog_shft !== 9'h0 || cfg_err !== 1'b1 || prog_i !== 32'h33) begin
        n_fail++;
        $display("FAIL bad%0d_ignore: shft=%h err=%b prog_i=%h expected 000/1/00000033",
                 i, prog_shft, cfg_err, prog_i);
      end
    end
  endtask

  task automatic test_valid_gaps();
    pulse_start();
    header(32'hA508_0003);
    step();
    payload(32'hAA);
    step();
    n_checks++;
    if (prog_shft !== 9'h100 || prog_i !== 32'hAA) begin
      n_fail++;
      $display("FAIL gap_w0: shft=%h prog_i=%h expected 100/000000aa", prog_shft, prog_i);
    end
    drive(1'b0, 32'hBB);
    step();
    n_checks++;
    if (prog_shft !== 9'h000 || prog_i !== 32'hAA) begin
      n_fail++;
      $display("FAIL gap_idle: shft=%h prog_i=%h expected 000/000000aa", prog_shft, prog_i);
    end
    payload(32'hCC);
    step();
    n_checks++;
    if (prog_shft !== 9'h100 || prog_i !== 32'hCC) begin
      n_fail++;
      $display("FAIL gap_w1: shft=%h prog_i=%h expected 100/000000cc", prog_shft, prog_i);
    end
    payload(32'hDD);
    step();
    n_checks++;
    if (prog_shft !== 9'h100 || prog_i !== 32'hDD || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_w2: shft=%h prog_i=%h err=%b expected 100/000000dd/0", prog_shft, prog_i, cfg_err);
    end
    end_frame();
    header(32'hA50F_0000);
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== 4'b0001) begin
      n_fail++;
      $display("FAIL gap_done: rdy/busy/err/fab=%b%b%b%b expected 0001", cfg_ready, cfg_busy, cfg_err, fabric_en);
    end
  endtask

  task automatic test_reset_midframe();
    pulse_start();
    header(32'hA503_0004);
    step();
    payload(32'h01);
    step();
    payload(32'h02);
    step();
    n_checks++;
    if (prog_shft !== 9'h008 || prog_i !== 32'h02) begin
      n_fail++;
      $display("FAIL mid_w1: shft=%h prog_i=%h expected 008/00000002", prog_shft, prog_i);
    end
    drive(1'b0, 32'h0);
    #2 res = 1'b1;
    #1;
    n_checks++;
    if ({prog_i, prog_shft, cfg_ready, fabric_en, data_en, cfg_busy, cfg_err} !== 46'h0) begin
      n_fail++;
      $display("FAIL mid_reset: prog_i=%h shft=%h rdy=%b fab=%b den=%b busy=%b err=%b expected all 0",
               prog_i, prog_shft, cfg_ready, fabric_en, data_en, cfg_busy, cfg_err);
    end
    step();
    res = 1'b0;
    drive(1'b1, 32'hA503_0001);
    step();
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, fabric_en} !== 3'b000 || prog_shft !== 9'h0) begin
      n_fail++;
      $display("FAIL mid_idle: rdy/busy/fab=%b%b%b shft=%h expected 000/000", cfg_ready, cfg_busy, fabric_en, prog_shft);
    end
    pulse_start();
    header(32'hA503_0004);
    step();
    for (int i = 0; i < 4; i++) begin
      payload(32'h100 + 32'(i));
      step();
      n_checks++;
      if (prog_shft !== 9'h008 || prog_i !== 32'h100 + 32'(i)) begin
        n_fail++;
        $display("FAIL mid_rerun%0d: shft=%h prog_i=%h expected 008/%h", i, prog_shft, prog_i, 32'h100 + 32'(i));
      end
    end
    end_frame();
    header(32'hA50F_0000);
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_done: rdy/busy/err/fab=%b%b%b%b expected 0001", cfg_ready, cfg_busy, cfg_err, fabric_en);
    end
  endtask

  task automatic test_start_ignored();
    data_en_i = 1'b1;
    pulse_start();
    n_checks++;
    if (fabric_en !== 1'b0 || data_en !== 1'b0) begin
      n_fail++;
      $display("FAIL st_restart: fab=%b den=%b expected 0/0", fabric_en, data_en);
    end
    header(32'hA502_0002);
    step();
    payload(32'h5);
    step();
    start = 1'b1;
    payload(32'h6);
    step();
    start = 1'b0;
    n_checks++;
    if (prog_shft !== 9'h004 || prog_i !== 32'h6 || cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL st_in_load: shft=%h prog_i=%h busy=%b expected 004/00000006/1", prog_shft, prog_i, cfg_busy);
    end
    end_frame();
    header(32'hA50F_0000);
    step();
    drive(1'b0, 32'h0);
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en, data_en} !== 5'b00011) begin
      n_fail++;
      $display("FAIL st_done: rdy/busy/err/fab/den=%b%b%b%b%b expected 00011",
               cfg_ready, cfg_busy, cfg_err, fabric_en, data_en);
    end
    data_en_i = 1'b0;
    #1;
    n_checks++;
    if (data_en !== 1'b0) begin
      n_fail++;
      $display("FAIL st_den_gate: den=%b expected 0", data_en);
    end
    data_en_i = 1'b1;
    pulse_start();
    n_checks++;
    if ({cfg_ready, cfg_busy, cfg_err, fabric_en, data_en} !== 5'b11000) begin
      n_fail++;
      $display("FAIL st_in_done: rdy/busy/err/fab/den=%b%b%b%b%b expected 11000",
               cfg_ready, cfg_busy, cfg_err, fabric_en, data_en);
    end
    header(32'hA50F_0000);
    step();
    drive(1'b0, 32'h0);
  endtask

`ifdef EFPGA_CFG_CRC_EN
  task automatic test_crc();
    logic [31:0] trl [2];
    logic [3:0]  exp_st [2];
    trl[0] = 32'h2144_DF1C; trl[1] = 32'h2144_DF1D;
    exp_st[0] = 4'b1100;    exp_st[1] = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      header(32'hA500_0001);
      step();
      payload(32'h0);
      step();
      n_checks++;
      if (prog_shft !== 9'h001 || prog_i !== 32'h0) begin
        n_fail++;
        $display("FAIL crc%0d_word: shft=%h prog_i=%h expected 001/00000000", i, prog_shft, prog_i);
      end
      drive(1'b1, trl[i]);
      step();
      drive(1'b0, 32'h0);
      n_checks++;
      if ({cfg_ready, cfg_busy, cfg_err, fabric_en} !== exp_st[i] || prog_shft !== 9'h0) begin
        n_fail++;
        $display("FAIL crc%0d_trailer: rdy/busy/err/fab=%b%b%b%b shft=%h expected %b/000",
                 i, cfg_ready, cfg_busy, cfg_err, fabric_en, prog_shft, exp_st[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_header();
    test_valid_gaps();
    test_reset_midframe();
    test_start_ignored();
`ifdef EFPGA_CFG_CRC_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
